serial_sync_ctrl: RTL

Word-alignment and lock controller for the 1-bit serial receive path.
- Hunts the incoming bit stream for the COMMA symbol and fixes the 8-bit word boundary.
- Confirms lock after repeated aligned commas, then strobes aligned 8-bit words to the byte/lane logic downstream.
- Detects loss of alignment and returns to hunting.
- Sits directly after the serial input pin and ahead of the parallel byte datapath.

---
 rtl/serial_sync_ctrl_pkg.sv | 21 ++
 rtl/serial_sync_ctrl_sync_shift_cmp.sv | 45 ++++
 rtl/serial_sync_ctrl.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/serial_sync_ctrl_pkg.sv
// serial_sync_ctrl_pkg
// Shared constants and types for the serial word-alignment controller:
// word width, counter widths, the default COMMA symbol and the FSM
// state encoding (HUNT=0, VERIFY=1, LOCKED=2).
// No ports.

package serial_sync_ctrl_pkg;

  localparam int WORD_W    = 8;
  localparam int CNT_W     = 4;
  localparam int BIT_CNT_W = 3;

  localparam logic [WORD_W-1:0] COMMA_DEFAULT = 8'hBC;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } sync_state_e;

endpackage

// File: rtl/serial_sync_ctrl_sync_shift_cmp.sv
// sync_shift_cmp
// Serial-to-parallel front end: holds the 8-bit shift register, forms the
// candidate word w = {sh[6:0], din} for the current bit and compares it
// against COMMA. The shift register only advances on EN=1 edges.
// Ports:
//   clk        in   receive bit clock
//   rst        in   asynchronous active-high reset
//   en         in   bit-valid qualifier
//   din        in   serial bit, MSB first
//   w          out  candidate word including the current bit
//   w_is_comma out  w equals COMMA

module sync_shift_cmp
  import serial_sync_ctrl_pkg::*;
#(
  parameter logic [WORD_W-1:0] COMMA = COMMA_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              din,
  output logic [WORD_W-1:0] w,
  output logic              w_is_comma
);

  logic [WORD_W-1:0] sh_q;
  logic [WORD_W-1:0] sh_d;

  // The word seen at this edge always includes the incoming bit, so every
  // decision in the controller is made on the freshest 8-bit window.
  always_comb begin
    w          = {sh_q[WORD_W-2:0], din};
    w_is_comma = (w == COMMA);
    sh_d       = en ? w : sh_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_q <= '0;
    end else begin
      sh_q <= sh_d;
    end
  end

endmodule

// File: rtl/serial_sync_ctrl.sv
// serial_sync_ctrl
// Word-alignment and lock controller for the 1-bit serial receive path.
// Hunts for COMMA, verifies LOCK_COMMAS aligned commas, then strobes each
// aligned word downstream; LOSS_ERRS misaligned commas drop back to HUNT.
// Optional macro SYNC_STATS_EN adds LOSS_COUNT (saturating LOCKED->HUNT count).
// Ports:
//   CLK        in   receive bit clock
//   RESET      in   asynchronous active-high reset
//   DATA_IN    in   serial bit, MSB first
//   EN         in   bit-valid qualifier; EN=0 freezes all state
//   DATA_OUT   out  last aligned word
//   VALID_OUT  out  one-cycle strobe for a new aligned word
//   IS_COMMA   out  the strobed word equals COMMA
//   SYNC_LOCK  out  high while LOCKED
//   STATE      out  current state
//   LOSS_COUNT out  (SYNC_STATS_EN only) number of sync losses

module serial_sync_ctrl
  import serial_sync_ctrl_pkg::*;
#(
  parameter logic [WORD_W-1:0] COMMA       = COMMA_DEFAULT,
  parameter int                LOCK_COMMAS = 3,
  parameter int                LOSS_ERRS   = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              DATA_IN,
  input  logic              EN,
  output logic [WORD_W-1:0] DATA_OUT,
  output logic              VALID_OUT,
  output logic              IS_COMMA,
  output logic              SYNC_LOCK,
  output logic [1:0]        STATE
`ifdef SYNC_STATS_EN
  ,
  output logic [7:0]        LOSS_COUNT
`endif
);

  localparam logic [CNT_W-1:0] LOCK_CNT = CNT_W'(LOCK_COMMAS);
  localparam logic [CNT_W-1:0] LOSS_CNT = CNT_W'(LOSS_ERRS);

  logic [WORD_W-1:0] w;
  logic              w_is_comma;
  logic              boundary;

  sync_state_e          state_q, state_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]     comma_cnt_q, comma_cnt_d;
  logic [CNT_W-1:0]     err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0]     comma_cnt_inc;
  logic [CNT_W-1:0]     err_cnt_inc;
  logic [WORD_W-1:0]    data_out_q, data_out_d;
  logic                 valid_q, valid_d;
  logic                 is_comma_q, is_comma_d;
`ifdef SYNC_STATS_EN
  logic [7:0]           loss_cnt_q, loss_cnt_d;
`endif

  sync_shift_cmp #(
    .COMMA(COMMA)
  ) u_shift_cmp (
    .clk       (CLK),
    .rst       (RESET),
    .en        (EN),
    .din       (DATA_IN),
    .w         (w),
    .w_is_comma(w_is_comma)
  );

  assign boundary      = EN && (bit_cnt_q == BIT_CNT_W'(7));
  assign comma_cnt_inc = comma_cnt_q + 1'b1;
  assign err_cnt_inc   = err_cnt_q + 1'b1;

  // State and counter registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= HUNT;
      bit_cnt_q   <= '0;
      comma_cnt_q <= '0;
      err_cnt_q   <= '0;
`ifdef SYNC_STATS_EN
      loss_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      comma_cnt_q <= comma_cnt_d;
      err_cnt_q   <= err_cnt_d;
`ifdef SYNC_STATS_EN
      loss_cnt_q  <= loss_cnt_d;
`endif
    end
  end

  // Next-state logic. A hunt hit re-zeros bit_cnt so the following word's
  // last bit lands on bit_cnt==7. The misaligned comma that causes a loss
  // is consumed here and cannot double as a hunt hit, since HUNT only
  // looks at later windows.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    comma_cnt_d = comma_cnt_q;
    err_cnt_d   = err_cnt_q;
    if (EN) begin
      bit_cnt_d = bit_cnt_q + 1'b1;
      unique case (state_q)
        HUNT: begin
          if (w_is_comma) begin
            bit_cnt_d   = '0;
            comma_cnt_d = CNT_W'(1);
            if (LOCK_CNT == CNT_W'(1)) begin
              state_d   = LOCKED;
              err_cnt_d = '0;
            end else begin
              state_d = VERIFY;
            end
          end
        end
        VERIFY: begin
          if (boundary) begin
            if (w_is_comma) begin
              comma_cnt_d = comma_cnt_inc;
              if (comma_cnt_inc == LOCK_CNT) begin
                state_d   = LOCKED;
                err_cnt_d = '0;
              end
            end else begin
              state_d     = HUNT;
              comma_cnt_d = '0;
            end
          end
        end
        LOCKED: begin
          if (boundary) begin
            if (w_is_comma) begin
              err_cnt_d = '0;
            end
          end else if (w_is_comma) begin
            if (err_cnt_inc == LOSS_CNT) begin
              state_d     = HUNT;
              err_cnt_d   = '0;
              comma_cnt_d = '0;
            end else begin
              err_cnt_d = err_cnt_inc;
            end
          end
        end
        default: begin
          state_d = HUNT;
        end
      endcase
    end
  end

`ifdef SYNC_STATS_EN
  // Count each LOCKED->HUNT transition, saturating at 8'hFF.
  always_comb begin
    loss_cnt_d = loss_cnt_q;
    if ((state_q == LOCKED) && (state_d == HUNT) && (loss_cnt_q != 8'hFF)) begin
      loss_cnt_d = loss_cnt_q + 8'd1;
    end
  end

  assign LOSS_COUNT = loss_cnt_q;
`endif

  // Output logic: words are only strobed at boundaries while LOCKED;
  // DATA_OUT and IS_COMMA hold between strobes.
  always_comb begin
    data_out_d = data_out_q;
    valid_d    = 1'b0;
    is_comma_d = is_comma_q;
    if (boundary && (state_q == LOCKED)) begin
      data_out_d = w;
      valid_d    = 1'b1;
      is_comma_d = w_is_comma;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      data_out_q <= '0;
      valid_q    <= 1'b0;
      is_comma_q <= 1'b0;
    end else begin
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      is_comma_q <= is_comma_d;
    end
  end

  assign DATA_OUT  = data_out_q;
  assign VALID_OUT = valid_q;
  assign IS_COMMA  = is_comma_q;
  assign SYNC_LOCK = (state_q == LOCKED);
  assign STATE     = state_q;

endmodule
